alu_ctrl_decode_stage: RTL and testbench

//  ID-stage decoder and ID/EX pipeline register for the MIPS core; the producer side of the ALU op interface.

---
 rtl/alu_ctrl_decode_stage_pkg.sv | 40 ++++
 rtl/alu_ctrl_decode_stage_if.sv | 19 +
 rtl/alu_ctrl_decode_stage_imm_extender.sv | 12 +
 rtl/alu_ctrl_decode_stage.sv | 95 +++++++++
 tb/tb_alu_ctrl_decode_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_decode_stage_pkg.sv
// alu_ctrl_decode_stage_pkg: MIPS opcode/funct constants and ALU op codes shared by ID and EX.
package alu_ctrl_decode_stage_pkg;
    localparam logic [5:0] IDLE_OP  = 6'b111111;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_SRA    = 6'h03;
    localparam logic [5:0] F_SLLV   = 6'h04;
    localparam logic [5:0] F_SRLV   = 6'h06;
    localparam logic [5:0] F_SRAV   = 6'h07;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_XOR    = 6'h26;
    localparam logic [5:0] F_NOR    = 6'h27;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [5:0] F_SLTU   = 6'h2B;

    typedef enum logic {EXT_ZERO = 1'b0, EXT_SIGN = 1'b1} ext_e;

    function automatic logic legal_funct(input logic [5:0] f);
        return f inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU,
                         F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
    endfunction

    function automatic logic legal_itype(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction
endpackage

// File: rtl/alu_ctrl_decode_stage_if.sv
// alu_ctrl_decode_stage_if: ALU op bus from the ID/EX register to the EX-stage ALU.
interface alu_ctrl_decode_stage_if #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6,
    parameter int NB_CNT  = 8
);
    logic               valid;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] datoA;
    logic [NB_DATA-1:0] datoB;
    logic [4:0]         shamt;
    logic [4:0]         rd_addr;
    logic               reg_write;
    logic               illegal;
    logic [NB_CNT-1:0]  illegal_cnt;

    modport master (output valid, alu_op, datoA, datoB, shamt, rd_addr, reg_write, illegal, illegal_cnt);
    modport slave  (input  valid, alu_op, datoA, datoB, shamt, rd_addr, reg_write, illegal, illegal_cnt);
endinterface

// File: rtl/alu_ctrl_decode_stage_imm_extender.sv
// alu_ctrl_decode_stage_imm_extender: widens imm16 to NB_DATA, sign- or zero-extending.
module alu_ctrl_decode_stage_imm_extender
    import alu_ctrl_decode_stage_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [15:0]        imm_i,
    input  ext_e               sign_sel_i,
    output logic [NB_DATA-1:0] ext_o
);
    assign ext_o = {{(NB_DATA-16){(sign_sel_i == EXT_SIGN) & imm_i[15]}}, imm_i};
endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// alu_ctrl_decode_stage: ID decoder and ID/EX register with stall, flush and saturating illegal counter.
module alu_ctrl_decode_stage
    import alu_ctrl_decode_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6,
    parameter int NB_CNT  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [NB_DATA-1:0]   i_instr,
    input  logic [NB_DATA-1:0]   i_rs_data,
    input  logic [NB_DATA-1:0]   i_rt_data,
    input  logic                 i_stall,
    input  logic                 i_flush,
    alu_ctrl_decode_stage_if.master alu_o
);
    logic [5:0]         opcode, funct;
    logic               r_type, i_type, legal, load, en;
    logic [4:0]         rd_sel;
    logic [NB_DATA-1:0] imm_ext;
    ext_e               sign_sel;
    logic               unused_rs;

    logic               valid_d, valid_q, reg_write_d, reg_write_q, illegal_d, illegal_q;
    logic [NB_OP-1:0]   op_d, op_q;
    logic [NB_DATA-1:0] a_d, a_q, b_d, b_q;
    logic [4:0]         shamt_d, shamt_q, rd_d, rd_q;
    logic [NB_CNT-1:0]  cnt_d, cnt_q;

    assign opcode    = i_instr[31:26];
    assign funct     = i_instr[5:0];
    assign unused_rs = ^i_instr[25:21];
    assign sign_sel  = opcode[2] ? EXT_ZERO : EXT_SIGN;

    alu_ctrl_decode_stage_imm_extender #(.NB_DATA(NB_DATA)) u_ext (
        .imm_i      (i_instr[15:0]),
        .sign_sel_i (sign_sel),
        .ext_o      (imm_ext)
    );

    always_comb begin
        r_type      = (opcode == OP_RTYPE) && legal_funct(funct);
        i_type      = legal_itype(opcode);
        legal       = r_type | i_type;
        load        = i_valid & ~i_flush;
        en          = i_flush | ~i_stall;
        rd_sel      = r_type ? i_instr[15:11] : i_instr[20:16];
        valid_d     = load;
        op_d        = !(load && legal) ? NB_OP'(IDLE_OP) : r_type ? NB_OP'(funct) : NB_OP'(opcode);
        a_d         = (load && legal) ? i_rs_data : '0;
        b_d         = !(load && legal) ? '0 : r_type ? i_rt_data : imm_ext;
        shamt_d     = load ? i_instr[10:6] : 5'd0;
        rd_d        = (load && legal) ? rd_sel : 5'd0;
        reg_write_d = load && legal && (rd_sel != 5'd0);
        illegal_d   = load && !legal;
        // saturate rather than wrap so a flood of bad words stays visible
        cnt_d       = (illegal_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            op_q        <= NB_OP'(IDLE_OP);
            a_q         <= '0;
            b_q         <= '0;
            shamt_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else if (en) begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            shamt_q     <= shamt_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alu_o.valid       = valid_q;
    assign alu_o.alu_op      = op_q;
    assign alu_o.datoA       = a_q;
    assign alu_o.datoB       = b_q;
    assign alu_o.shamt       = shamt_q;
    assign alu_o.rd_addr     = rd_q;
    assign alu_o.reg_write   = reg_write_q;
    assign alu_o.illegal     = illegal_q;
    assign alu_o.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// tb_alu_ctrl_decode_stage: directed vectors with hand-computed expectations for the ID/EX stage.
module tb_alu_ctrl_decode_stage;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_instr = '0;
    logic [31:0] i_rs_data = '0;
    logic [31:0] i_rt_data = '0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    int          total = 0;
    int          bad = 0;

    alu_ctrl_decode_stage_if #(.NB_DATA(32), .NB_OP(6), .NB_CNT(8)) bus ();

    alu_ctrl_decode_stage #(.NB_DATA(32), .NB_OP(6), .NB_CNT(8)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .i_instr   (i_instr),
        .i_rs_data (i_rs_data),
        .i_rt_data (i_rt_data),
        .i_stall   (i_stall),
        .i_flush   (i_flush),
        .alu_o     (bus.master)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        i_valid   = v;
        i_instr   = ins;
        i_rs_data = rs;
        i_rt_data = rt;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_op"}, 32'(bus.alu_op), 32'h3F);
        chk({tag, "_rw"}, 32'(bus.reg_write), 32'd0);
        chk({tag, "_ill"}, 32'(bus.illegal), 32'd0);
        chk({tag, "_A"}, bus.datoA, 32'd0);
        chk({tag, "_B"}, bus.datoB, 32'd0);
        chk({tag, "_rd"}, 32'(bus.rd_addr), 32'd0);
        chk({tag, "_sh"}, 32'(bus.shamt), 32'd0);
    endtask

    initial begin
        #12;
        chk_bubble("rst");
        chk("rst_cnt", 32'(bus.illegal_cnt), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        drive(1, 32'h00221820, 32'd5, 32'd7);
        tick();
        chk("add_op", 32'(bus.alu_op), 32'h20);
        chk("add_A", bus.datoA, 32'd5);
        chk("add_B", bus.datoB, 32'd7);
        chk("add_rd", 32'(bus.rd_addr), 32'd3);
        chk("add_rw", 32'(bus.reg_write), 32'd1);
        chk("add_valid", 32'(bus.valid), 32'd1);
        chk("add_ill", 32'(bus.illegal), 32'd0);

        drive(1, 32'h2024FFFF, 32'd9, 32'h1234);
        tick();
        chk("addi_op", 32'(bus.alu_op), 32'h08);
        chk("addi_A", bus.datoA, 32'd9);
        chk("addi_B", bus.datoB, 32'hFFFFFFFF);
        chk("addi_rd", 32'(bus.rd_addr), 32'd4);

        drive(1, 32'h34058000, 32'd0, 32'd0);
        tick();
        chk("ori_op", 32'(bus.alu_op), 32'h0D);
        chk("ori_B", bus.datoB, 32'h00008000);
        chk("ori_rd", 32'(bus.rd_addr), 32'd5);

        drive(1, 32'h3021FFFF, 32'd3, 32'd0);
        tick();
        chk("andi_op", 32'(bus.alu_op), 32'h0C);
        chk("andi_B", bus.datoB, 32'h0000FFFF);
        chk("andi_rd", 32'(bus.rd_addr), 32'd1);

        drive(1, 32'h000230C3, 32'd0, 32'hF0000000);
        tick();
        chk("sra_op", 32'(bus.alu_op), 32'h03);
        chk("sra_sh", 32'(bus.shamt), 32'd3);
        chk("sra_rd", 32'(bus.rd_addr), 32'd6);
        chk("sra_B", bus.datoB, 32'hF0000000);

        drive(1, 32'h00000000, 32'd1, 32'd2);
        tick();
        chk("nop_op", 32'(bus.alu_op), 32'h00);
        chk("nop_valid", 32'(bus.valid), 32'd1);
        chk("nop_rw", 32'(bus.reg_write), 32'd0);

        drive(1, 32'hFC000000, 32'd1, 32'd2);
        tick();
        chk("ill_op", 32'(bus.alu_op), 32'h3F);
        chk("ill_ill", 32'(bus.illegal), 32'd1);
        chk("ill_rw", 32'(bus.reg_write), 32'd0);
        chk("ill_valid", 32'(bus.valid), 32'd1);
        chk("ill_cnt", 32'(bus.illegal_cnt), 32'd1);

        drive(0, 32'h00221820, 32'd5, 32'd7);
        tick();
        chk_bubble("inval");
        chk("inval_cnt", 32'(bus.illegal_cnt), 32'd1);

        drive(1, 32'h00221820, 32'd5, 32'd7);
        tick();
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'hFC000000 + 32'(k), 32'(k + 100), 32'(k + 200));
            tick();
            chk("stall_op", 32'(bus.alu_op), 32'h20);
            chk("stall_A", bus.datoA, 32'd5);
            chk("stall_B", bus.datoB, 32'd7);
            chk("stall_rd", 32'(bus.rd_addr), 32'd3);
            chk("stall_cnt", 32'(bus.illegal_cnt), 32'd1);
        end
        i_flush = 1'b1;
        drive(1, 32'h00221820, 32'd5, 32'd7);
        tick();
        chk_bubble("stflush");
        i_stall = 1'b0;
        i_flush = 1'b0;
        tick();
        chk("reload_op", 32'(bus.alu_op), 32'h20);
        i_flush = 1'b1;
        tick();
        chk_bubble("flush");
        i_flush = 1'b0;

        drive(1, 32'h00000001, 32'd0, 32'd0);
        tick();
        chk("badfunct_ill", 32'(bus.illegal), 32'd1);
        chk("badfunct_cnt", 32'(bus.illegal_cnt), 32'd2);

        drive(1, 32'hFC000000, 32'd0, 32'd0);
        for (int k = 0; k < 252; k++) tick();
        chk("cnt_254", 32'(bus.illegal_cnt), 32'd254);
        tick();
        chk("cnt_255", 32'(bus.illegal_cnt), 32'd255);
        for (int k = 0; k < 47; k++) tick();
        chk("cnt_sat", 32'(bus.illegal_cnt), 32'd255);

        drive(1, 32'h00221820, 32'd5, 32'd7);
        tick();
        chk("pre_rst_op", 32'(bus.alu_op), 32'h20);
        i_stall = 1'b1;
        #2 i_rst = 1'b1;
        #1;
        chk_bubble("async_rst");
        chk("async_rst_cnt", 32'(bus.illegal_cnt), 32'd0);
        tick();
        @(negedge i_clk);
        i_rst = 1'b0;
        i_stall = 1'b0;
        tick();
        chk("post_rst_op", 32'(bus.alu_op), 32'h20);
        chk("post_rst_valid", 32'(bus.valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
